fork_split: RTL and testbench
=============================

FORK_SPLIT -- requirements
Module: fork_split

Interface
REQ-001 SHALL have parameter N, default 4, giving the number of downstream branches (N>=2).
REQ-002 SHALL have parameter W, default 32, giving the payload data width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_master_valid, input, 1, upstream beat valid.
REQ-006 SHALL have port o_master_ready, output, 1, upstream beat accepted by all selected branches.
REQ-007 SHALL have port i_master_end, input, 1, last beat of packet.
REQ-008 SHALL have port i_master_data, input, W, beat payload.
REQ-009 SHALL have port i_master_mask, input, N, branch select, sampled on the first beat of a packet.
REQ-010 SHALL have port o_slave_valid, output, N, per-branch beat valid.
REQ-011 SHALL have port i_slave_ready, input, N, per-branch ready.
REQ-012 SHALL have port o_slave_data, output, W, payload broadcast to all branches (equals i_master_data).
REQ-013 SHALL have port o_slave_end, output, 1, broadcast end flag (equals i_master_end).
REQ-014 SHALL have port o_pkt_cnt, output, 16, count of completed packets, wrapping at 2^16.

Function
REQ-015 SHALL implement a packet FSM with states IDLE (awaiting first beat) and PKT (inside multi-beat packet).
REQ-016 SHALL use effective mask m = i_master_mask in IDLE and m = r_mask in PKT.
REQ-017 SHALL hold per-branch flag r_taken[k], set when o_slave_valid[k] & i_slave_ready[k] occur and the beat is not yet complete.
REQ-018 SHALL drive o_slave_valid[k] = i_master_valid & m[k] & !r_taken[k], combinationally.
REQ-019 SHALL drive o_master_ready = AND over k of (!m[k] | r_taken[k] | i_slave_ready[k]), combinationally, with zero added latency.
REQ-020 SHALL define beat completion as i_master_valid & o_master_ready; on completion all r_taken clear in the same edge.
REQ-021 SHALL, on completion in IDLE with !i_master_end, latch r_mask <= i_master_mask and enter PKT.
REQ-022 SHALL, on completion with i_master_end, return to (or stay in) IDLE and increment o_pkt_cnt by 1, wrapping 0xFFFF -> 0x0000.
REQ-023 SHALL treat m == 0 as drop: o_master_ready = 1, no o_slave_valid asserted, and the packet is still counted on its end beat.
REQ-024 SHALL present each beat exactly once per selected branch; a branch that has taken the beat is never re-offered it.
REQ-025 SHALL make simultaneous acceptance by all remaining branches complete the beat in that cycle, with no r_taken set.
REQ-026 SHALL retain r_taken if i_master_valid drops before completion (protocol violation); upstream must hold valid, data, end and mask stable until ready.
REQ-027 SHALL make i_master_mask changes during PKT have no effect.

Reset
REQ-028 SHALL, while i_reset is high, force state IDLE, r_taken = 0, r_mask = 0, o_pkt_cnt = 0, asynchronously.
REQ-029 SHALL derive o_slave_valid and o_master_ready from inputs under reset with r_taken = 0 and state IDLE; no beat completes or is counted until reset is released.
REQ-030 SHALL, on reset mid-packet, discard the partial packet; the next beat is treated as a first beat.

Structure
REQ-031 SHALL take the FSM state typedef (IDLE, PKT) from the shared stream package stream_pkg, alongside the combine-stage types.
REQ-032 SHALL place per-branch valid/taken logic in one sub-module fork_branch, instantiated N times in a generate loop.

Verification
REQ-033 SHALL verify single beat, N=4, mask 4'b1111, all slave ready = 1 -> o_master_ready = 1 in the same cycle, o_pkt_cnt 0 -> 1.
REQ-034 SHALL verify staggered ready: branches 0..3 ready in cycles 1,2,3,4 -> each o_slave_valid[k] drops after its own accept, o_master_ready = 1 only in cycle 4.
REQ-035 SHALL verify a 3-beat packet, first-beat mask 4'b0101, mask changed to 4'b1111 on beats 2-3 -> only branches 0 and 2 see valid on all 3 beats, o_pkt_cnt +1.
REQ-036 SHALL verify mask 4'b0000, 2-beat packet -> no slave valid, ready = 1 both beats, o_pkt_cnt +1.
REQ-037 SHALL verify reset pulse after branch 1 has taken beat 2 of 4 -> after release r_taken = 0, state IDLE, o_pkt_cnt = 0, next beat samples a new mask.
REQ-038 SHALL verify counter wrap: preload 65535 packets (or force) then one packet -> o_pkt_cnt = 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream-stage types: packet FSM states for the fork stage and combine-stage types.
package stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } fork_state_t;

  typedef enum logic [1:0] {
    CMB_IDLE    = 2'd0,
    CMB_COLLECT = 2'd1,
    CMB_EMIT    = 2'd2
  } combine_state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/fork_branch.sv
// One fork branch: offers the current beat once and remembers that it was taken.
module fork_branch (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_master_valid,
  input  logic i_mask_bit,
  input  logic i_slave_ready,
  input  logic i_beat_done,
  output logic o_slave_valid,
  output logic o_branch_ok
);

  logic taken_r;

  always_comb begin
    o_slave_valid = i_master_valid & i_mask_bit & ~taken_r;
    o_branch_ok   = ~i_mask_bit | taken_r | i_slave_ready;
  end

  // Taken flag survives a dropped valid and clears only when the whole beat completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      taken_r <= 1'b0;
    end else if (i_beat_done) begin
      taken_r <= 1'b0;
    end else if (o_slave_valid & i_slave_ready) begin
      taken_r <= 1'b1;
    end else begin
      taken_r <= taken_r;
    end
  end

endmodule

// File: rtl/fork_split.sv
// Broadcasts each upstream beat to a masked subset of N branches; completes when all have taken it.
module fork_split
  import stream_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_master_valid,
  output logic                 o_master_ready,
  input  logic                 i_master_end,
  input  logic [W-1:0]         i_master_data,
  input  logic [N-1:0]         i_master_mask,
  output logic [N-1:0]         o_slave_valid,
  input  logic [N-1:0]         i_slave_ready,
  output logic [W-1:0]         o_slave_data,
  output logic                 o_slave_end,
  output logic [PKT_CNT_W-1:0] o_pkt_cnt
);

  fork_state_t            state_r;
  fork_state_t            next_state_s;
  logic [N-1:0]           mask_r;
  logic [N-1:0]           eff_mask_s;
  logic [N-1:0]           branch_ok_s;
  logic                   beat_done_s;
  logic [PKT_CNT_W-1:0]   pkt_cnt_r;

  always_comb begin
    if (state_r == ST_IDLE) begin
      eff_mask_s = i_master_mask;
    end else begin
      eff_mask_s = mask_r;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_branch
      fork_branch u_branch (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_master_valid (i_master_valid),
        .i_mask_bit     (eff_mask_s[k]),
        .i_slave_ready  (i_slave_ready[k]),
        .i_beat_done    (beat_done_s),
        .o_slave_valid  (o_slave_valid[k]),
        .o_branch_ok    (branch_ok_s[k])
      );
    end
  endgenerate

  assign o_master_ready = &branch_ok_s;
  assign beat_done_s    = i_master_valid & o_master_ready;
  assign o_slave_data   = i_master_data;
  assign o_slave_end    = i_master_end;
  assign o_pkt_cnt      = pkt_cnt_r;

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (beat_done_s & ~i_master_end) next_state_s = ST_PKT;
        else                             next_state_s = ST_IDLE;
      end
      ST_PKT: begin
        if (beat_done_s & i_master_end) next_state_s = ST_IDLE;
        else                            next_state_s = ST_PKT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Mask is frozen on the first beat so later mask changes inside a packet are ignored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      mask_r    <= '0;
      pkt_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (beat_done_s & (state_r == ST_IDLE) & ~i_master_end) begin
        mask_r <= i_master_mask;
      end else begin
        mask_r <= mask_r;
      end
      if (beat_done_s & i_master_end) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_fork_split.sv
// Directed bench for fork_split (N=4, W=32) with hand-computed expectations.
module tb_fork_split;

  logic        i_clk;
  logic        i_reset;
  logic        i_master_valid;
  logic        o_master_ready;
  logic        i_master_end;
  logic [31:0] i_master_data;
  logic [3:0]  i_master_mask;
  logic [3:0]  o_slave_valid;
  logic [3:0]  i_slave_ready;
  logic [31:0] o_slave_data;
  logic        o_slave_end;
  logic [15:0] o_pkt_cnt;

  int n_total = 0;
  int n_pass  = 0;

  fork_split #(.N(4), .W(32)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_master_valid (i_master_valid),
    .o_master_ready (o_master_ready),
    .i_master_end   (i_master_end),
    .i_master_data  (i_master_data),
    .i_master_mask  (i_master_mask),
    .o_slave_valid  (o_slave_valid),
    .i_slave_ready  (i_slave_ready),
    .o_slave_data   (o_slave_data),
    .o_slave_end    (o_slave_end),
    .o_pkt_cnt      (o_pkt_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and land 1 time unit after it, ready to drive new inputs.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [3:0] m, input logic [3:0] r);
    i_master_valid = v;
    i_master_end   = e;
    i_master_mask  = m;
    i_slave_ready  = r;
    #1;
  endtask

  initial begin
    i_reset = 1'b1;
    i_master_data = 32'h0000_0000;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk("rst_cnt", {16'd0, o_pkt_cnt}, 32'd0);
    chk("rst_valid", {28'd0, o_slave_valid}, 32'd0);
    chk("rst_ready_nomask", {31'd0, o_master_ready}, 32'd1);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000);
    chk("rst_valid_comb", {28'd0, o_slave_valid}, 32'h0000_000F);
    chk("rst_ready_comb", {31'd0, o_master_ready}, 32'd0);
    tick();
    tick();
    chk("rst_no_count", {16'd0, o_pkt_cnt}, 32'd0);
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    i_reset = 1'b0;
    tick();

    // Single beat, all branches ready at once.
    i_master_data = 32'hA5A5_1234;
    drive(1'b1, 1'b1, 4'b1111, 4'b1111);
    chk("single_ready", {31'd0, o_master_ready}, 32'd1);
    chk("single_valid", {28'd0, o_slave_valid}, 32'h0000_000F);
    chk("single_data", o_slave_data, 32'hA5A5_1234);
    chk("single_end", {31'd0, o_slave_end}, 32'd1);
    tick();
    chk("single_cnt", {16'd0, o_pkt_cnt}, 32'd1);

    // Staggered readiness, with a valid drop after branch 0 has taken the beat.
    drive(1'b1, 1'b1, 4'b1111, 4'b0001);
    chk("stag1_valid", {28'd0, o_slave_valid}, 32'h0000_000F);
    chk("stag1_ready", {31'd0, o_master_ready}, 32'd0);
    tick();
    drive(1'b0, 1'b1, 4'b1111, 4'b0000);
    chk("drop_valid", {28'd0, o_slave_valid}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b0010);
    chk("stag2_valid", {28'd0, o_slave_valid}, 32'h0000_000E);
    chk("stag2_ready", {31'd0, o_master_ready}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b0100);
    chk("stag3_valid", {28'd0, o_slave_valid}, 32'h0000_000C);
    chk("stag3_ready", {31'd0, o_master_ready}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b1000);
    chk("stag4_valid", {28'd0, o_slave_valid}, 32'h0000_0008);
    chk("stag4_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    chk("stag_cnt", {16'd0, o_pkt_cnt}, 32'd2);

    // Three-beat packet: mask sampled on beat 1, ignored afterwards.
    drive(1'b1, 1'b0, 4'b0101, 4'b1111);
    chk("pkt_b1_valid", {28'd0, o_slave_valid}, 32'h0000_0005);
    chk("pkt_b1_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("pkt_b2_valid", {28'd0, o_slave_valid}, 32'h0000_0005);
    chk("pkt_b2_wait", {31'd0, o_master_ready}, 32'd0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0101);
    chk("pkt_b2_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b1010);
    chk("pkt_b3_valid", {28'd0, o_slave_valid}, 32'h0000_0005);
    chk("pkt_b3_wait", {31'd0, o_master_ready}, 32'd0);
    drive(1'b1, 1'b1, 4'b1111, 4'b1111);
    chk("pkt_b3_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    chk("pkt_cnt", {16'd0, o_pkt_cnt}, 32'd3);

    // Zero mask drops the packet but still counts it.
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk("drop_b1_valid", {28'd0, o_slave_valid}, 32'd0);
    chk("drop_b1_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b0000);
    chk("drop_b2_valid", {28'd0, o_slave_valid}, 32'd0);
    chk("drop_b2_ready", {31'd0, o_master_ready}, 32'd1);
    tick();
    chk("drop_cnt", {16'd0, o_pkt_cnt}, 32'd4);

    // Reset in the middle of beat 2 after branch 1 has taken it.
    drive(1'b1, 1'b0, 4'b1111, 4'b1111);
    tick();
    drive(1'b1, 1'b0, 4'b1111, 4'b0010);
    tick();
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("mid_taken", {28'd0, o_slave_valid}, 32'h0000_000D);
    i_reset = 1'b1;
    #1;
    chk("mid_rst_cnt", {16'd0, o_pkt_cnt}, 32'd0);
    chk("mid_rst_taken", {28'd0, o_slave_valid}, 32'h0000_000F);
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    i_reset = 1'b0;
    tick();
    drive(1'b1, 1'b0, 4'b0011, 4'b0000);
    chk("post_rst_newmask", {28'd0, o_slave_valid}, 32'h0000_0003);
    drive(1'b1, 1'b0, 4'b0011, 4'b1111);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b0000);
    chk("post_rst_latched", {28'd0, o_slave_valid}, 32'h0000_0003);
    drive(1'b1, 1'b1, 4'b1111, 4'b1111);
    tick();
    chk("post_rst_cnt", {16'd0, o_pkt_cnt}, 32'd1);

    // Counter wrap: 65534 more single-beat packets reach 65535, one more wraps.
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    chk("cnt_max", {16'd0, o_pkt_cnt}, 32'h0000_FFFF);
    tick();
    chk("cnt_wrap", {16'd0, o_pkt_cnt}, 32'd0);
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk("cnt_hold", {16'd0, o_pkt_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
